// File: rtl/ex_stage.sv
// Execute stage of the 5-stage RV32I pipeline: operand forwarding, ALU, branch/jump
// resolution with a combinational fetch redirect, and the EX/MEM pipeline register.
`ifndef CONTROL_SIGNALS_WIDTH
`define CONTROL_SIGNALS_WIDTH 8
`endif

module ex_stage (
  input  logic                              clk,
  input  logic                              reset_n,
  input  logic                              stall,
  input  logic                              flush,
  input  logic                              id_ex_valid,
  input  logic [31:0]                       id_ex_pc,
  input  logic [31:0]                       id_ex_instruction,
  input  logic [31:0]                       id_ex_rs1_data,
  input  logic [31:0]                       id_ex_rs2_data,
  input  logic [31:0]                       id_ex_immediate,
  input  logic [4:0]                        id_ex_rd_addr,
  input  logic [4:0]                        id_ex_rs1_addr,
  input  logic [4:0]                        id_ex_rs2_addr,
  input  logic [`CONTROL_SIGNALS_WIDTH-1:0] id_ex_control_signals,
  input  logic [4:0]                        mem_wb_rd_addr,
  input  logic [31:0]                       mem_wb_rd_data,
  input  logic                              mem_wb_reg_write,
  output logic [31:0]                       ex_mem_pc,
  output logic [31:0]                       ex_mem_instruction,
  output logic [31:0]                       ex_mem_alu_result,
  output logic [31:0]                       ex_mem_store_data,
  output logic [4:0]                        ex_mem_rd_addr,
  output logic [`CONTROL_SIGNALS_WIDTH-1:0] ex_mem_control_signals,
  output logic                              ex_mem_reg_write,
  output logic                              ex_mem_valid,
  output logic                              branch_redirect,
  output logic [31:0]                       branch_target
);

  localparam logic [6:0] OPC_OP     = 7'b0110011;
  localparam logic [6:0] OPC_OP_IMM = 7'b0010011;
  localparam logic [6:0] OPC_LOAD   = 7'b0000011;
  localparam logic [6:0] OPC_STORE  = 7'b0100011;
  localparam logic [6:0] OPC_BRANCH = 7'b1100011;
  localparam logic [6:0] OPC_JAL    = 7'b1101111;
  localparam logic [6:0] OPC_JALR   = 7'b1100111;
  localparam logic [6:0] OPC_LUI    = 7'b0110111;
  localparam logic [6:0] OPC_AUIPC  = 7'b0010111;

  logic [6:0]  opcode_s;
  logic [2:0]  funct3_s;
  logic        funct7_5_s;
  logic        ex_fwd_ok_s;
  logic [31:0] fwd_rs1_s;
  logic [31:0] fwd_rs2_s;
  logic [31:0] op_b_s;
  logic [4:0]  shamt_s;
  logic [31:0] alu_s;
  logic [31:0] result_s;
  logic [31:0] pc_plus_4_s;
  logic [31:0] pc_plus_imm_s;
  logic [31:0] rs1_plus_imm_s;
  logic        taken_s;
  logic        writes_rd_s;
  logic        reg_write_s;

  assign opcode_s       = id_ex_instruction[6:0];
  assign funct3_s       = id_ex_instruction[14:12];
  assign funct7_5_s     = id_ex_instruction[30];
  assign pc_plus_4_s    = id_ex_pc + 32'd4;
  assign pc_plus_imm_s  = id_ex_pc + id_ex_immediate;
  assign rs1_plus_imm_s = fwd_rs1_s + id_ex_immediate;
  assign shamt_s        = op_b_s[4:0];

  // A load in EX/MEM has no data yet; its consumer is held back by the hazard unit.
  assign ex_fwd_ok_s = ex_mem_valid & ex_mem_reg_write & (ex_mem_instruction[6:0] != OPC_LOAD);

  // rs1 forwarding: EX/MEM first, then MEM/WB, never for x0
  always_comb begin
    fwd_rs1_s = id_ex_rs1_data;
    if (id_ex_rs1_addr == 5'd0) begin
      fwd_rs1_s = id_ex_rs1_data;
    end else if (ex_fwd_ok_s && (ex_mem_rd_addr == id_ex_rs1_addr)) begin
      fwd_rs1_s = ex_mem_alu_result;
    end else if (mem_wb_reg_write && (mem_wb_rd_addr == id_ex_rs1_addr)) begin
      fwd_rs1_s = mem_wb_rd_data;
    end else begin
      fwd_rs1_s = id_ex_rs1_data;
    end
  end

  // rs2 forwarding: same priority as rs1
  always_comb begin
    fwd_rs2_s = id_ex_rs2_data;
    if (id_ex_rs2_addr == 5'd0) begin
      fwd_rs2_s = id_ex_rs2_data;
    end else if (ex_fwd_ok_s && (ex_mem_rd_addr == id_ex_rs2_addr)) begin
      fwd_rs2_s = ex_mem_alu_result;
    end else if (mem_wb_reg_write && (mem_wb_rd_addr == id_ex_rs2_addr)) begin
      fwd_rs2_s = mem_wb_rd_data;
    end else begin
      fwd_rs2_s = id_ex_rs2_data;
    end
  end

  // Operand B selection
  always_comb begin
    op_b_s = fwd_rs2_s;
    case (opcode_s)
      OPC_OP_IMM, OPC_LOAD, OPC_STORE,
      OPC_JALR, OPC_LUI, OPC_AUIPC: op_b_s = id_ex_immediate;
      default:                      op_b_s = fwd_rs2_s;
    endcase
  end

  // ALU for OP / OP-IMM; only register-register OP may subtract
  always_comb begin
    alu_s = 32'd0;
    case (funct3_s)
      3'b000:  alu_s = ((opcode_s == OPC_OP) && funct7_5_s) ? (fwd_rs1_s - op_b_s)
                                                             : (fwd_rs1_s + op_b_s);
      3'b001:  alu_s = fwd_rs1_s << shamt_s;
      3'b010:  alu_s = {31'd0, ($signed(fwd_rs1_s) < $signed(op_b_s))};
      3'b011:  alu_s = {31'd0, (fwd_rs1_s < op_b_s)};
      3'b100:  alu_s = fwd_rs1_s ^ op_b_s;
      3'b101:  alu_s = funct7_5_s ? $unsigned($signed(fwd_rs1_s) >>> shamt_s)
                                  : (fwd_rs1_s >> shamt_s);
      3'b110:  alu_s = fwd_rs1_s | op_b_s;
      3'b111:  alu_s = fwd_rs1_s & op_b_s;
      default: alu_s = 32'd0;
    endcase
  end

  // Result selection by opcode
  always_comb begin
    result_s = 32'd0;
    case (opcode_s)
      OPC_OP, OPC_OP_IMM:  result_s = alu_s;
      OPC_LUI:             result_s = id_ex_immediate;
      OPC_AUIPC:           result_s = pc_plus_imm_s;
      OPC_JAL, OPC_JALR:   result_s = pc_plus_4_s;
      OPC_LOAD, OPC_STORE: result_s = rs1_plus_imm_s;
      default:             result_s = 32'd0;
    endcase
  end

  // Branch condition on forwarded register operands
  always_comb begin
    taken_s = 1'b0;
    case (funct3_s)
      3'b000:  taken_s = (fwd_rs1_s == fwd_rs2_s);
      3'b001:  taken_s = (fwd_rs1_s != fwd_rs2_s);
      3'b100:  taken_s = ($signed(fwd_rs1_s) < $signed(fwd_rs2_s));
      3'b101:  taken_s = !($signed(fwd_rs1_s) < $signed(fwd_rs2_s));
      3'b110:  taken_s = (fwd_rs1_s < fwd_rs2_s);
      3'b111:  taken_s = !(fwd_rs1_s < fwd_rs2_s);
      default: taken_s = 1'b0;
    endcase
  end

  // Redirect target; pc+imm whenever not JALR keeps it X-free
  always_comb begin
    if (opcode_s == OPC_JALR) begin
      branch_target = {rs1_plus_imm_s[31:1], 1'b0};
    end else begin
      branch_target = pc_plus_imm_s;
    end
  end

  assign branch_redirect = id_ex_valid & ~stall & ~flush &
                           (((opcode_s == OPC_BRANCH) & taken_s) |
                            (opcode_s == OPC_JAL) | (opcode_s == OPC_JALR));

  // Opcodes that produce a register result
  always_comb begin
    writes_rd_s = 1'b0;
    case (opcode_s)
      OPC_OP, OPC_OP_IMM, OPC_LUI, OPC_AUIPC,
      OPC_JAL, OPC_JALR, OPC_LOAD: writes_rd_s = 1'b1;
      default:                     writes_rd_s = 1'b0;
    endcase
  end

  assign reg_write_s = id_ex_valid & writes_rd_s & (id_ex_rd_addr != 5'd0);

  // EX/MEM pipeline register: flush beats stall
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      ex_mem_pc              <= 32'd0;
      ex_mem_instruction     <= 32'd0;
      ex_mem_alu_result      <= 32'd0;
      ex_mem_store_data      <= 32'd0;
      ex_mem_rd_addr         <= 5'd0;
      ex_mem_control_signals <= {`CONTROL_SIGNALS_WIDTH{1'b0}};
      ex_mem_reg_write       <= 1'b0;
      ex_mem_valid           <= 1'b0;
    end else if (flush) begin
      ex_mem_pc              <= 32'd0;
      ex_mem_instruction     <= 32'd0;
      ex_mem_alu_result      <= 32'd0;
      ex_mem_store_data      <= 32'd0;
      ex_mem_rd_addr         <= 5'd0;
      ex_mem_control_signals <= {`CONTROL_SIGNALS_WIDTH{1'b0}};
      ex_mem_reg_write       <= 1'b0;
      ex_mem_valid           <= 1'b0;
    end else if (!stall) begin
      ex_mem_pc              <= id_ex_pc;
      ex_mem_instruction     <= id_ex_instruction;
      ex_mem_alu_result      <= result_s;
      ex_mem_store_data      <= fwd_rs2_s;
      ex_mem_rd_addr         <= id_ex_rd_addr;
      ex_mem_control_signals <= id_ex_control_signals;
      ex_mem_reg_write       <= reg_write_s;
      ex_mem_valid           <= id_ex_valid;
    end
  end

endmodule

// File: tb/tb_ex_stage.sv
// Scoreboard bench for ex_stage: expectations are queued when an instruction is
// presented and popped after the capturing edge.
`ifndef CONTROL_SIGNALS_WIDTH
`define CONTROL_SIGNALS_WIDTH 8
`endif

module tb_ex_stage;
  localparam int CW = `CONTROL_SIGNALS_WIDTH;
  localparam logic [6:0] OP = 7'b0110011, OPI = 7'b0010011, LD = 7'b0000011;
  localparam logic [6:0] ST = 7'b0100011, BR = 7'b1100011, JAL = 7'b1101111;
  localparam logic [6:0] JALR = 7'b1100111, LUI = 7'b0110111, AUIPC = 7'b0010111;

  logic clk = 1'b0;
  logic reset_n, stall, flush, id_ex_valid;
  logic [31:0] id_ex_pc, id_ex_instruction, id_ex_rs1_data, id_ex_rs2_data, id_ex_immediate;
  logic [4:0] id_ex_rd_addr, id_ex_rs1_addr, id_ex_rs2_addr;
  logic [CW-1:0] id_ex_control_signals;
  logic [4:0] mem_wb_rd_addr;
  logic [31:0] mem_wb_rd_data;
  logic mem_wb_reg_write;
  logic [31:0] ex_mem_pc, ex_mem_instruction, ex_mem_alu_result, ex_mem_store_data;
  logic [4:0] ex_mem_rd_addr;
  logic [CW-1:0] ex_mem_control_signals;
  logic ex_mem_reg_write, ex_mem_valid, branch_redirect;
  logic [31:0] branch_target;

  typedef struct packed {
    logic [31:0] pc;
    logic [31:0] res;
    logic [31:0] st;
    logic [4:0]  rd;
    logic        rw;
    logic        v;
    logic [CW-1:0] ctrl;
  } exp_t;

  exp_t sb_q[$];
  exp_t e, held, got;
  int n_checks = 0;
  int n_fails = 0;

  assign got = {ex_mem_pc, ex_mem_alu_result, ex_mem_store_data, ex_mem_rd_addr,
                ex_mem_reg_write, ex_mem_valid, ex_mem_control_signals};

  ex_stage dut (
    .clk(clk), .reset_n(reset_n), .stall(stall), .flush(flush), .id_ex_valid(id_ex_valid),
    .id_ex_pc(id_ex_pc), .id_ex_instruction(id_ex_instruction),
    .id_ex_rs1_data(id_ex_rs1_data), .id_ex_rs2_data(id_ex_rs2_data),
    .id_ex_immediate(id_ex_immediate), .id_ex_rd_addr(id_ex_rd_addr),
    .id_ex_rs1_addr(id_ex_rs1_addr), .id_ex_rs2_addr(id_ex_rs2_addr),
    .id_ex_control_signals(id_ex_control_signals),
    .mem_wb_rd_addr(mem_wb_rd_addr), .mem_wb_rd_data(mem_wb_rd_data),
    .mem_wb_reg_write(mem_wb_reg_write),
    .ex_mem_pc(ex_mem_pc), .ex_mem_instruction(ex_mem_instruction),
    .ex_mem_alu_result(ex_mem_alu_result), .ex_mem_store_data(ex_mem_store_data),
    .ex_mem_rd_addr(ex_mem_rd_addr), .ex_mem_control_signals(ex_mem_control_signals),
    .ex_mem_reg_write(ex_mem_reg_write), .ex_mem_valid(ex_mem_valid),
    .branch_redirect(branch_redirect), .branch_target(branch_target)
  );

  always #5 clk = ~clk;

  function automatic logic [31:0] ins(input logic [6:0] f7, input logic [2:0] f3,
                                      input logic [6:0] op);
    ins = {f7, 10'd0, f3, 5'd0, op};
  endfunction

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic present(input logic [31:0] instr, input logic [31:0] pc, input logic [4:0] rd,
                         input logic [4:0] rs1a, input logic [31:0] rs1d,
                         input logic [4:0] rs2a, input logic [31:0] rs2d,
                         input logic [31:0] imm);
    id_ex_valid = 1'b1;
    id_ex_instruction = instr;
    id_ex_pc = pc;
    id_ex_rd_addr = rd;
    id_ex_rs1_addr = rs1a;
    id_ex_rs1_data = rs1d;
    id_ex_rs2_addr = rs2a;
    id_ex_rs2_data = rs2d;
    id_ex_immediate = imm;
    id_ex_control_signals = CW'({rd, 3'b101});
  endtask

  task automatic push_exp(input logic [31:0] res, input logic [4:0] rd, input logic rw,
                          input logic [31:0] st);
    exp_t x;
    x.pc = id_ex_pc;
    x.res = res;
    x.st = st;
    x.rd = rd;
    x.rw = rw;
    x.v = 1'b1;
    x.ctrl = id_ex_control_signals;
    sb_q.push_back(x);
  endtask

  task automatic test_reset();
    tick();
    n_checks++;
    if (got !== '0) begin n_fails++; $display("FAIL reset_state: got %h exp 0", got); end
    reset_n = 1'b1;
    present(ins(7'd0, 3'b000, OPI), 32'h10, 5'd1, 5'd0, 32'd0, 5'd0, 32'd0, 32'd5);
    push_exp(32'd5, 5'd1, 1'b1, 32'd0);
    tick(); e = sb_q.pop_front(); n_checks++;
    if (got !== e) begin n_fails++; $display("FAIL addi_first: got %h exp %h", got, e); end
    reset_n = 1'b0;
    #2;
    n_checks++;
    if (got !== '0) begin n_fails++; $display("FAIL async_reset: got %h exp 0", got); end
    reset_n = 1'b1;
    push_exp(32'd5, 5'd1, 1'b1, 32'd0);
    tick(); e = sb_q.pop_front(); n_checks++;
    if (got !== e) begin n_fails++; $display("FAIL reset_release: got %h exp %h", got, e); end
  endtask

  task automatic test_forwarding();
    present(ins(7'd0, 3'b000, OP), 32'h14, 5'd3, 5'd1, 32'd5, 5'd2, 32'd7, 32'd0);
    push_exp(32'd12, 5'd3, 1'b1, 32'd7);
    tick(); e = sb_q.pop_front(); n_checks++;
    if (got !== e) begin n_fails++; $display("FAIL add_x3: got %h exp %h", got, e); end
    present(ins(7'h20, 3'b000, OP), 32'h18, 5'd4, 5'd3, 32'd0, 5'd1, 32'd5, 32'd0);
    mem_wb_reg_write = 1'b1; mem_wb_rd_addr = 5'd3; mem_wb_rd_data = 32'd99;
    push_exp(32'd7, 5'd4, 1'b1, 32'd5);
    tick(); e = sb_q.pop_front(); n_checks++;
    if (got !== e) begin n_fails++; $display("FAIL sub_exmem_wins: got %h exp %h", got, e); end
    present(ins(7'd0, 3'b000, OP), 32'h1c, 5'd5, 5'd6, 32'd0, 5'd0, 32'd0, 32'd0);
    mem_wb_rd_addr = 5'd6; mem_wb_rd_data = 32'd40;
    push_exp(32'd40, 5'd5, 1'b1, 32'd0);
    tick(); e = sb_q.pop_front(); n_checks++;
    if (got !== e) begin n_fails++; $display("FAIL memwb_fwd: got %h exp %h", got, e); end
    present(ins(7'd0, 3'b000, OP), 32'h20, 5'd7, 5'd0, 32'd0, 5'd0, 32'd0, 32'd0);
    mem_wb_rd_addr = 5'd0; mem_wb_rd_data = 32'd123;
    push_exp(32'd0, 5'd7, 1'b1, 32'd0);
    tick(); e = sb_q.pop_front(); n_checks++;
    if (got !== e) begin n_fails++; $display("FAIL x0_not_fwd: got %h exp %h", got, e); end
    mem_wb_reg_write = 1'b0;
    present(ins(7'd0, 3'b010, LD), 32'h24, 5'd8, 5'd0, 32'd0, 5'd0, 32'd0, 32'h20);
    push_exp(32'h20, 5'd8, 1'b1, 32'd0);
    tick(); e = sb_q.pop_front(); n_checks++;
    if (got !== e) begin n_fails++; $display("FAIL load_addr: got %h exp %h", got, e); end
    present(ins(7'd0, 3'b000, OP), 32'h28, 5'd9, 5'd8, 32'd3, 5'd0, 32'd0, 32'd0);
    push_exp(32'd3, 5'd9, 1'b1, 32'd0);
    tick(); e = sb_q.pop_front(); n_checks++;
    if (got !== e) begin n_fails++; $display("FAIL load_no_fwd: got %h exp %h", got, e); end
  endtask

  task automatic test_branches();
    present(ins(7'd0, 3'b000, BR), 32'h100, 5'd0, 5'd10, 32'd10, 5'd11, 32'd10, 32'd8);
    #1; n_checks++;
    if ({branch_redirect, branch_target} !== {1'b1, 32'h108}) begin
      n_fails++; $display("FAIL beq: got %b/%h exp 1/00000108", branch_redirect, branch_target);
    end
    push_exp(32'd0, 5'd0, 1'b0, 32'd10);
    tick(); e = sb_q.pop_front(); n_checks++;
    if (got !== e) begin n_fails++; $display("FAIL beq_captured: got %h exp %h", got, e); end
    present(ins(7'd0, 3'b001, BR), 32'h100, 5'd0, 5'd10, 32'd10, 5'd11, 32'd10, 32'd8);
    #1; n_checks++;
    if (branch_redirect !== 1'b0) begin n_fails++; $display("FAIL bne: got %b exp 0", branch_redirect); end
    tick();
    present(ins(7'd0, 3'b100, BR), 32'h100, 5'd0, 5'd10, 32'hFFFFFFFB, 5'd11, 32'd2, 32'd8);
    #1; n_checks++;
    if (branch_redirect !== 1'b1) begin n_fails++; $display("FAIL blt: got %b exp 1", branch_redirect); end
    tick();
    present(ins(7'd0, 3'b110, BR), 32'h100, 5'd0, 5'd10, 32'hFFFFFFFB, 5'd11, 32'd2, 32'd8);
    #1; n_checks++;
    if (branch_redirect !== 1'b0) begin n_fails++; $display("FAIL bltu: got %b exp 0", branch_redirect); end
    tick();
  endtask

  task automatic test_jumps();
    present(ins(7'd0, 3'b000, JALR), 32'h200, 5'd1, 5'd12, 32'h301, 5'd0, 32'd0, 32'd4);
    #1; n_checks++;
    if ({branch_redirect, branch_target} !== {1'b1, 32'h304}) begin
      n_fails++; $display("FAIL jalr_target: got %b/%h exp 1/00000304", branch_redirect, branch_target);
    end
    push_exp(32'h204, 5'd1, 1'b1, 32'd0);
    tick(); e = sb_q.pop_front(); n_checks++;
    if (got !== e) begin n_fails++; $display("FAIL jalr_link: got %h exp %h", got, e); end
    present(ins(7'd0, 3'b000, JAL), 32'h40, 5'd0, 5'd0, 32'd0, 5'd0, 32'd0, 32'hFFFFFFF0);
    #1; n_checks++;
    if ({branch_redirect, branch_target} !== {1'b1, 32'h30}) begin
      n_fails++; $display("FAIL jal_target: got %b/%h exp 1/00000030", branch_redirect, branch_target);
    end
    push_exp(32'h44, 5'd0, 1'b0, 32'd0);
    tick(); e = sb_q.pop_front(); n_checks++;
    if (got !== e) begin n_fails++; $display("FAIL jal_link: got %h exp %h", got, e); end
  endtask

  task automatic test_stall_flush();
    present(ins(7'd0, 3'b000, OPI), 32'h500, 5'd2, 5'd0, 32'd0, 5'd0, 32'd0, 32'd9);
    push_exp(32'd9, 5'd2, 1'b1, 32'd0);
    tick(); e = sb_q.pop_front(); n_checks++;
    if (got !== e) begin n_fails++; $display("FAIL pre_stall: got %h exp %h", got, e); end
    held = e;
    stall = 1'b1;
    for (int k = 0; k < 3; k++) begin
      if (k == 0) present(ins(7'd0, 3'b000, JAL), 32'h504, 5'd1, 5'd0, 32'd0, 5'd0, 32'd0, 32'd64);
      else if (k == 1) present(ins(7'd0, 3'b000, OPI), 32'h508, 5'd5, 5'd0, 32'd0, 5'd0, 32'd0, 32'd77);
      else present(ins(7'd0, 3'b000, OP), 32'h50c, 5'd3, 5'd2, 32'd0, 5'd0, 32'd0, 32'd0);
      #1; n_checks++;
      if (branch_redirect !== 1'b0) begin
        n_fails++; $display("FAIL stall_redirect[%0d]: got %b exp 0", k, branch_redirect);
      end
      sb_q.push_back(held);
      tick(); e = sb_q.pop_front(); n_checks++;
      if (got !== e) begin n_fails++; $display("FAIL stall_hold[%0d]: got %h exp %h", k, got, e); end
    end
    stall = 1'b0;
    push_exp(32'd9, 5'd3, 1'b1, 32'd0);
    tick(); e = sb_q.pop_front(); n_checks++;
    if (got !== e) begin n_fails++; $display("FAIL stall_fwd: got %h exp %h", got, e); end
    present(ins(7'd0, 3'b000, JAL), 32'h600, 5'd6, 5'd0, 32'd0, 5'd0, 32'd0, 32'd16);
    stall = 1'b1; flush = 1'b1;
    #1; n_checks++;
    if (branch_redirect !== 1'b0) begin n_fails++; $display("FAIL flush_redirect: got %b exp 0", branch_redirect); end
    sb_q.push_back('0);
    tick(); e = sb_q.pop_front(); n_checks++;
    if (got !== e) begin n_fails++; $display("FAIL flush_beats_stall: got %h exp %h", got, e); end
    stall = 1'b0; flush = 1'b0;
    present(ins(7'd0, 3'b000, OPI), 32'h604, 5'd0, 5'd0, 32'd0, 5'd0, 32'd0, 32'd1);
    push_exp(32'd1, 5'd0, 1'b0, 32'd0);
    tick(); e = sb_q.pop_front(); n_checks++;
    if (got !== e) begin n_fails++; $display("FAIL addi_x0: got %h exp %h", got, e); end
  endtask

  task automatic test_alu();
    for (int k = 0; k < 9; k++) begin
      case (k)
        0: begin present(ins(7'h20, 3'b101, OP), 32'h0, 5'd20, 5'd13, 32'h80000000, 5'd14, 32'd33, 32'd0);
                 push_exp(32'hC0000000, 5'd20, 1'b1, 32'd33); end
        1: begin present(ins(7'd0, 3'b011, OP), 32'h0, 5'd21, 5'd13, 32'd1, 5'd14, 32'hFFFFFFFF, 32'd0);
                 push_exp(32'd1, 5'd21, 1'b1, 32'hFFFFFFFF); end
        2: begin present(ins(7'd0, 3'b010, OP), 32'h0, 5'd22, 5'd13, 32'd1, 5'd14, 32'hFFFFFFFF, 32'd0);
                 push_exp(32'd0, 5'd22, 1'b1, 32'hFFFFFFFF); end
        3: begin present(ins(7'd0, 3'b101, OPI), 32'h0, 5'd23, 5'd13, 32'h80000000, 5'd0, 32'd0, 32'd4);
                 push_exp(32'h08000000, 5'd23, 1'b1, 32'd0); end
        4: begin present(ins(7'h20, 3'b101, OPI), 32'h0, 5'd24, 5'd13, 32'h80000000, 5'd0, 32'd0, 32'h404);
                 push_exp(32'hF8000000, 5'd24, 1'b1, 32'd0); end
        5: begin present(ins(7'd0, 3'b100, OP), 32'h0, 5'd25, 5'd13, 32'hF0F0F0F0, 5'd14, 32'h0FF00FF0, 32'd0);
                 push_exp(32'hFF00FF00, 5'd25, 1'b1, 32'h0FF00FF0); end
        6: begin present(ins(7'd0, 3'b000, LUI), 32'h0, 5'd26, 5'd0, 32'd0, 5'd0, 32'd0, 32'h12345000);
                 push_exp(32'h12345000, 5'd26, 1'b1, 32'd0); end
        7: begin present(ins(7'd0, 3'b000, AUIPC), 32'h1000, 5'd27, 5'd0, 32'd0, 5'd0, 32'd0, 32'h2000);
                 push_exp(32'h3000, 5'd27, 1'b1, 32'd0); end
        default: begin present(ins(7'd0, 3'b010, ST), 32'h0, 5'd0, 5'd13, 32'h1000, 5'd14, 32'hDEADBEEF, 32'h10);
                 push_exp(32'h1010, 5'd0, 1'b0, 32'hDEADBEEF); end
      endcase
      tick(); e = sb_q.pop_front(); n_checks++;
      if (got !== e) begin n_fails++; $display("FAIL alu_case[%0d]: got %h exp %h", k, got, e); end
    end
    present(ins(7'd0, 3'b000, OP), 32'h0, 5'd28, 5'd13, 32'hFFFFFFFF, 5'd14, 32'd2, 32'd0);
    push_exp(32'd1, 5'd28, 1'b1, 32'd2);
    tick(); e = sb_q.pop_front(); n_checks++;
    if (got !== e) begin n_fails++; $display("FAIL add_wrap: got %h exp %h", got, e); end
  endtask

  initial begin
    reset_n = 1'b0; stall = 1'b0; flush = 1'b0; id_ex_valid = 1'b0;
    id_ex_pc = 32'd0; id_ex_instruction = 32'd0; id_ex_rs1_data = 32'd0; id_ex_rs2_data = 32'd0;
    id_ex_immediate = 32'd0; id_ex_rd_addr = 5'd0; id_ex_rs1_addr = 5'd0; id_ex_rs2_addr = 5'd0;
    id_ex_control_signals = '0;
    mem_wb_rd_addr = 5'd0; mem_wb_rd_data = 32'd0; mem_wb_reg_write = 1'b0;
    test_reset();
    test_forwarding();
    test_branches();
    test_jumps();
    test_stall_flush();
    test_alu();
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fails);
    $finish;
  end

endmodule

// File: doc/ex_stage.md
# ex_stage

Execute stage of the 5-stage RV32I pipeline. It consumes the ID/EX register that `id_stage` drives and forwards operands from its own EX/MEM register and from MEM/WB. It runs the ALU, resolves branches and jumps (issuing a redirect to fetch), and registers results into the EX/MEM pipeline register for the memory stage.

## Interface
- Parameters: none. The datapath is fixed at 32 bits. `CONTROL_SIGNALS_WIDTH` comes from `constants.v`.
- `clk`  in  1  pipeline clock, rising edge
- `reset_n`  in  1  asynchronous, active-low reset
- `stall`  in  1  hold the EX/MEM register
- `flush`  in  1  insert a bubble into EX/MEM
- `id_ex_valid`  in  1  ID/EX holds a real instruction
- `id_ex_pc`, `id_ex_instruction`, `id_ex_rs1_data`, `id_ex_rs2_data`, `id_ex_immediate`  in  32 each  ID/EX fields
- `id_ex_rd_addr`, `id_ex_rs1_addr`, `id_ex_rs2_addr`  in  5 each  register indices
- `id_ex_control_signals`  in  `CONTROL_SIGNALS_WIDTH`  passed through unchanged
- `mem_wb_rd_addr`  in  5 / `mem_wb_rd_data`  in  32 / `mem_wb_reg_write`  in  1  writeback forwarding source
- `ex_mem_pc`, `ex_mem_instruction`, `ex_mem_alu_result`, `ex_mem_store_data`  out  32 each  registered
- `ex_mem_rd_addr`  out  5 / `ex_mem_control_signals`  out  `CONTROL_SIGNALS_WIDTH`  registered
- `ex_mem_reg_write`  out  1 / `ex_mem_valid`  out  1  registered
- `branch_redirect`  out  1  combinational; fetch must load `branch_target`
- `branch_target`  out  32  combinational

## Operation
- **Operand forwarding**, applied per source independently, in priority order:
  1. EX/MEM, if `ex_mem_valid`, `ex_mem_reg_write`, the EX/MEM instruction is not LOAD, and rd==rs.
  2. MEM/WB, if `mem_wb_reg_write` and `mem_wb_rd_addr`==rs.
  3. Otherwise `id_ex_rsX_data`.
  - rs==0 is never forwarded.
  - The load-use bubble is the hazard unit's job, not this block's.
- **Operand B**: the immediate for OP-IMM, LOAD, STORE, JALR, LUI and AUIPC; the forwarded rs2 otherwise.
- **ALU, OP/OP-IMM** (funct3):
  - 000: ADD. SUB only for OP with funct7[5]=1.
  - 001: SLL. 101: SRL, or SRA when funct7[5]=1.
  - 010: SLT (signed). 011: SLTU (unsigned).
  - 100: XOR. 110: OR. 111: AND.
  - Shift amount is the low 5 bits of operand B. Add/sub wrap modulo 2^32.
- **Result by opcode**:
  - LUI: imm. AUIPC: pc+imm.
  - JAL/JALR: pc+4.
  - LOAD/STORE: rs1+imm.
  - BRANCH: 0. Any other opcode: 0.
- **`ex_mem_store_data`**: forwarded rs2.
- **Branch compare** (funct3): 000 EQ, 001 NE, 100 LT, 101 GE, 110 LTU, 111 GEU. Funct3 010 and 011 are never taken.
- **Targets**: BRANCH and JAL use pc+imm. JALR uses (fwd_rs1+imm) with bit0 cleared.
- **`branch_redirect`** = `id_ex_valid` & !`stall` & !`flush` & (taken branch | JAL | JALR).
- **Register-write flag** = `id_ex_valid` & opcode ∈ {OP, OP-IMM, LUI, AUIPC, JAL, JALR, LOAD} & rd≠0.
- **EX/MEM register update**, highest priority first:
  1. `reset_n`=0: all fields 0.
  2. `flush`: all fields 0, including valid and reg_write.
  3. `stall`: hold.
  4. Otherwise load the computed values. `ex_mem_valid` takes `id_ex_valid`.
  - Flush beats stall.
- An instruction that redirects is itself captured valid into EX/MEM. Squashing younger instructions is upstream's responsibility.

## Timing
- Reset is asynchronous: every output register clears immediately on `reset_n` falling, with no clock edge needed.
- Release is synchronous to the next rising edge.
- Latency: one cycle from ID/EX presentation to EX/MEM outputs.
- `branch_redirect` and `branch_target` settle in the same cycle as their ID/EX inputs.
- Back-to-back dependent instructions forward from EX/MEM with zero bubbles.
- A value written 2 instructions earlier forwards from MEM/WB.
- With both sources matching, EX/MEM wins.
- During `stall`, the forwarding source stays the held EX/MEM content.
- `branch_target` is don't-care when `branch_redirect`=0, but must be deterministic (no X).

## Test plan
- **Async reset**: drive `reset_n`=0 mid-run between clock edges → all `ex_mem_*` outputs are 0 and `ex_mem_valid`=0 before the next edge. On release with ADDI x1,x0,5, the next edge gives result 5.
- **Forwarding**:
  - ADD x3,x1,x2 with rs1=5, rs2=7 → result 12, rd 3, reg_write 1, valid 1.
  - Next cycle, SUB x4,x3,x1 with stale rs1_data=0 and rs1=5, while MEM/WB writes x3=99 → result 7, because EX/MEM beats MEM/WB.
- **Branches**, pc=0x100, imm=8:
  - BEQ with 10/10 → redirect 1, target 0x108.
  - BNE with 10/10 → redirect 0.
  - BLT with -5/2 → redirect 1. BLTU with 0xFFFFFFFB/2 → redirect 0.
- **Jumps**:
  - JALR with pc=0x200, rs1=0x301, imm=4 → target 0x304, result 0x204, redirect 1.
  - JAL with pc=0x40, imm=-0x10 → target 0x30.
- **Stall, flush and x0**:
  - `stall`=1 for 3 cycles with changing inputs → outputs held, `branch_redirect`=0.
  - `stall`=1 and `flush`=1 together → `ex_mem_valid`=0 next edge.
  - ADDI x0,x0,1 → reg_write 0.
  - MEM/WB write to x0 → not forwarded.
- **Shifts and compares**:
  - SRA of 0x80000000 by 33 → 0xC0000000.
  - SLTU 1 < 0xFFFFFFFF → 1. SLT of the same values → 0.
